// File: rtl/disp_pkg.sv
// Shared display definitions: FSM state codes, blank byte, hex->segment table.
// Latency: none (constants and a pure function only).
// Backpressure: not applicable.
package disp_pkg;

    // Feeder FSM states, 2-bit encoded.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // All segments and the decimal point off (active-low).
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low segment bytes for hex 0..F with the decimal point off.
    // Bits [6:0] are ~{g,f,e,d,c,b,a}; bit 7 is ~dp.
    // Entry 15 comes first in the concatenation, entry 0 last.
    localparam logic [15:0][7:0] SEG_LUT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E d C
        8'h83, 8'h88, 8'h90, 8'h80,   // b A 9 8
        8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
        8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
    };

    // Full byte for one digit: blank wins over both the hex value and dp.
    function automatic logic [7:0] seg_encode(input logic [3:0] hex,
                                              input logic       dp,
                                              input logic       blank);
        logic [7:0] lut_byte;
        lut_byte = SEG_LUT[hex];
        if (blank) begin
            return SEG_BLANK;
        end
        return {~dp, lut_byte[6:0]};
    endfunction

endpackage

// File: rtl/hex2seg.sv
// Combinational hex digit to active-low 7-segment byte encoder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the output follows the inputs.
module hex2seg
    import disp_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    // Table lookup, with blank forcing every segment and dp off.
    always_comb begin
        seg = seg_encode(hex, dp, blank);
    end

endmodule

// File: rtl/seg_frame_feeder.sv
// Captures a frame of hex digits and feeds its encoded segment bytes, MSD first, to the P2S serializer.
// Latency: LOAD one cycle after req is accepted; at least 3 cycles per digit; frame_done NUM_DIGITS*3+1 cycles after req.
// Backpressure: each byte waits for a qualified p2s_done (wait count >= 2); req is ignored while busy; the frame aborts with sticky err after TIMEOUT wait cycles.
module seg_frame_feeder
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int BIT_WIDTH  = 8,   // the segment encoding fills exactly 8 bits
    parameter int TIMEOUT    = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic [4*NUM_DIGITS-1:0] hex_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    err,
    output logic                    p2s_start,
    output logic [BIT_WIDTH-1:0]    p2s_data,
    input  logic                    p2s_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_QUAL  = CNT_W'(2);

    state_t state, state_n;

    // Captured frame; later input changes never disturb a frame in flight.
    logic [3:0]            hex_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dp_q;
    logic [NUM_DIGITS-1:0] blank_q;

    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] wcnt;
    logic [7:0]       data_hold;
    logic [7:0]       seg_byte;

    // Control strobes from the FSM to the datapath.
    logic capture;
    logic idx_dec;
    logic set_err;

    hex2seg u_hex2seg (
        .hex   (hex_q[idx]),
        .dp    (dp_q[idx]),
        .blank (blank_q[idx]),
        .seg   (seg_byte)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and output decode; a timeout takes priority over a late done.
    always_comb begin
        state_n    = state;
        busy       = 1'b0;
        p2s_start  = 1'b0;
        frame_done = 1'b0;
        capture    = 1'b0;
        idx_dec    = 1'b0;
        set_err    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy      = 1'b1;
                p2s_start = 1'b1;
                state_n   = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (wcnt >= CNT_LIMIT) begin
                    set_err = 1'b1;
                    state_n = ST_IDLE;
                end else if (p2s_done && (wcnt >= CNT_QUAL)) begin
                    if (idx != '0) begin
                        idx_dec = 1'b1;
                        state_n = ST_LOAD;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
                state_n    = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Frame capture on an accepted request; err is cleared here so it reads 0 during LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                hex_q[i] <= 4'h0;
            end
            dp_q    <= '0;
            blank_q <= '0;
        end else if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                hex_q[i] <= hex_in[4*i +: 4];
            end
            dp_q    <= dp_in;
            blank_q <= blank_in;
        end
    end

    // Digit index: starts at the MSD and steps down after each completed byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (capture) begin
            idx <= IDX_LAST;
        end else if (idx_dec) begin
            idx <= idx - 1'b1;
        end
    end

    // Wait counter reads 1 in the first WAIT cycle and counts up from there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= '0;
        end else if (state == ST_LOAD) begin
            wcnt <= CNT_W'(1);
        end else if (state == ST_WAIT) begin
            wcnt <= wcnt + 1'b1;
        end
    end

    // Sticky timeout flag, cleared only when the next frame is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (capture) begin
            err <= 1'b0;
        end else if (set_err) begin
            err <= 1'b1;
        end
    end

    // Byte holding register: keeps the last issued byte on p2s_data until the next LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_hold <= SEG_BLANK;
        end else if (state == ST_LOAD) begin
            data_hold <= seg_byte;
        end
    end

    // In LOAD the fresh byte is driven directly so it is valid alongside the start pulse.
    always_comb begin
        if (state == ST_LOAD) begin
            p2s_data = BIT_WIDTH'(seg_byte);
        end else begin
            p2s_data = BIT_WIDTH'(data_hold);
        end
    end

endmodule

// File: tb/tb_seg_frame_feeder.sv
// Scoreboard bench for seg_frame_feeder with a behavioural serializer model.
// Latency: n/a (testbench).
// Backpressure: the serializer model drives p2s_done with configurable delays.
module tb_seg_frame_feeder;

    localparam int ND = 8;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] hex_in;
    logic [7:0]  dp_in;
    logic [7:0]  blank_in;
    logic        busy;
    logic        frame_done;
    logic        err;
    logic        p2s_start;
    logic [7:0]  p2s_data;
    logic        p2s_done = 1'b0;

    always #5 clk = ~clk;

    seg_frame_feeder #(
        .NUM_DIGITS (ND),
        .BIT_WIDTH  (8),
        .TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .hex_in     (hex_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err),
        .p2s_start  (p2s_start),
        .p2s_data   (p2s_data),
        .p2s_done   (p2s_done)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];
    int         start_cyc[$];
    int         fd_pending = 0;
    int         fd_count   = 0;

    // serializer model controls: 0 tied high, 1 latency, 2 stuck low, 3 pulses at ser_pa/ser_pb
    int ser_mode = 0;
    int ser_lat  = 0;
    int ser_pa   = 1;
    int ser_pb   = 1;
    bit lat_rand = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference encoder: lit segments per hex digit in positive logic {g,f,e,d,c,b,a}.
    function automatic logic [7:0] ref_enc(input logic [3:0] h, input logic d, input logic b);
        logic [6:0] lit;
        case (h)
            4'h0: lit = 7'b0111111; 4'h1: lit = 7'b0000110;
            4'h2: lit = 7'b1011011; 4'h3: lit = 7'b1001111;
            4'h4: lit = 7'b1100110; 4'h5: lit = 7'b1101101;
            4'h6: lit = 7'b1111101; 4'h7: lit = 7'b0000111;
            4'h8: lit = 7'b1111111; 4'h9: lit = 7'b1101111;
            4'hA: lit = 7'b1110111; 4'hB: lit = 7'b1111100;
            4'hC: lit = 7'b0111001; 4'hD: lit = 7'b1011110;
            4'hE: lit = 7'b1111001; default: lit = 7'b1110001;
        endcase
        if (b) return 8'hFF;
        return {~d, ~lit};
    endfunction

    // Serializer model: tracks cycles since the last start pulse.
    int ser_k   = 0;
    int cur_lat = 0;
    always @(negedge clk) begin
        if (p2s_start) begin
            ser_k   = 0;
            cur_lat = lat_rand ? int'($urandom_range(0, 12)) : ser_lat;
        end else begin
            ser_k = ser_k + 1;
        end
        case (ser_mode)
            0:       p2s_done = 1'b1;
            1:       p2s_done = (ser_k >= cur_lat);
            2:       p2s_done = 1'b0;
            default: p2s_done = (ser_k == ser_pa) || (ser_k == ser_pb);
        endcase
    end

    // Monitor: pops expected bytes on each start, checks frame completion bookkeeping.
    bit         prev_start = 1'b0;
    logic [7:0] exp_byte;
    always @(negedge clk) begin
        if (rst) begin
            prev_start = 1'b0;
        end else begin
            if (p2s_start) begin
                check("start_not_back_to_back", 32'(prev_start), 0);
                check("busy_with_start", 32'(busy), 1);
                start_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_start: got data %0h, expected no start (cycle %0d)", p2s_data, cyc);
                end else begin
                    exp_byte = exp_q.pop_front();
                    check("p2s_data", 32'(p2s_data), 32'(exp_byte));
                end
            end
            if (frame_done) begin
                fd_count++;
                check("frame_done_expected", 32'(fd_pending > 0), 1);
                check("frame_done_all_bytes", exp_q.size(), 0);
                if (fd_pending > 0) fd_pending--;
            end
            prev_start = p2s_start;
        end
    end

    // Issue a frame in cycle t0 and push its expected bytes; returns at the LOAD cycle.
    task automatic send_frame(input logic [31:0] h, input logic [7:0] d, input logic [7:0] b,
                              input int n_exp, input bit want_fd, output int t0);
        for (int i = ND - 1; i >= 0; i--) begin
            if ((ND - 1 - i) < n_exp) exp_q.push_back(ref_enc(h[4*i +: 4], d[i], b[i]));
        end
        if (want_fd) fd_pending++;
        hex_in   = h;
        dp_in    = d;
        blank_in = b;
        req      = 1'b1;
        t0       = cyc;
        @(negedge clk);
        req      = 1'b0;
        hex_in   = $urandom;
        dp_in    = 8'($urandom);
        blank_in = 8'($urandom);
    endtask

    task automatic wait_fd(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (frame_done) begin
                seen = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_gaps(input string name, input int base, input int gap);
        check({name, "_starts"}, start_cyc.size() - base, ND);
        for (int i = 1; i < ND; i++) begin
            if (base + i < start_cyc.size())
                check({name, "_gap"}, start_cyc[base+i] - start_cyc[base+i-1], gap);
        end
    endtask

    initial begin
        int t0;
        int base;
        int fdb;
        bit seen;

        rst      = 1'b1;
        req      = 1'b0;
        hex_in   = '0;
        dp_in    = '0;
        blank_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_start", 32'(p2s_start), 0);
        check("rst_data", 32'(p2s_data), 32'hFF);
        rst = 1'b0;
        @(negedge clk);

        // Digits 0..7, done tied high: minimum cadence
        ser_mode = 0;
        send_frame(32'h0123_4567, 8'h00, 8'h00, ND, 1'b1, t0);
        check("A_load_start", 32'(p2s_start), 1);
        check("A_load_busy", 32'(busy), 1);
        wait_fd(60, seen);
        check("A_fd_seen", 32'(seen), 1);
        check("A_fd_cycle", cyc - t0, 25);
        @(negedge clk);
        check("A_busy_low", 32'(busy), 0);
        check("A_idle_cycle", cyc - t0, 26);

        // Back-to-back request from the first idle cycle; blank MSD, dp on digit 0
        send_frame(32'h8888_8888, 8'h01, 8'h80, ND, 1'b1, t0);
        check("B_load_next", 32'(p2s_start), 1);
        wait_fd(60, seen);
        check("B_fd_seen", 32'(seen), 1);
        @(negedge clk);

        // Serializer latency 9 with a stray req mid-frame
        ser_mode = 1; ser_lat = 9; lat_rand = 1'b0;
        base = start_cyc.size();
        fdb  = fd_count;
        send_frame($urandom, 8'($urandom), 8'($urandom), ND, 1'b1, t0);
        for (int i = 0; i < 40; i++) begin
            if (start_cyc.size() - base >= 2) break;
            @(negedge clk);
        end
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_fd(200, seen);
        check("C_fd_seen", 32'(seen), 1);
        repeat (20) @(negedge clk);
        check_gaps("C", base, 10);
        check("C_fd_once", fd_count - fdb, 1);

        // Stuck-low done: timeout after TO wait cycles, err sticky until next accept
        ser_mode = 2;
        fdb = fd_count;
        send_frame($urandom, 8'($urandom), 8'($urandom), 1, 1'b0, t0);
        for (int i = 0; i < 100; i++) begin
            if (err) break;
            @(negedge clk);
        end
        check("TO_err", 32'(err), 1);
        check("TO_cycle", cyc - t0, TO + 2);
        check("TO_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        check("TO_err_sticky", 32'(err), 1);
        check("TO_no_fd", fd_count - fdb, 0);
        ser_mode = 0;
        send_frame($urandom, 8'($urandom), 8'($urandom), ND, 1'b1, t0);
        check("TO_err_clear_at_load", 32'(err), 0);
        check("TO_next_start", 32'(p2s_start), 1);
        wait_fd(60, seen);
        check("TO_next_fd", 32'(seen), 1);
        @(negedge clk);

        // Done only at counts 1 and 5: the count-1 pulse must be ignored
        ser_mode = 3; ser_pa = 1; ser_pb = 5;
        base = start_cyc.size();
        send_frame($urandom, 8'($urandom), 8'($urandom), ND, 1'b1, t0);
        wait_fd(100, seen);
        check("E_fd_seen", 32'(seen), 1);
        @(negedge clk);
        check_gaps("E", base, 6);

        // Done only at count TO-1: last acceptable moment
        ser_pa = TO - 1; ser_pb = TO - 1;
        base = start_cyc.size();
        send_frame($urandom, 8'($urandom), 8'($urandom), ND, 1'b1, t0);
        wait_fd(ND * TO + 20, seen);
        check("F_fd_seen", 32'(seen), 1);
        check("F_no_err", 32'(err), 0);
        @(negedge clk);
        check_gaps("F", base, TO);

        // Reset during the third LOAD
        ser_mode = 0;
        base = start_cyc.size();
        send_frame($urandom, 8'($urandom), 8'($urandom), ND, 1'b1, t0);
        #1;
        for (int i = 0; i < 40; i++) begin
            if (start_cyc.size() - base >= 3) break;
            @(negedge clk);
            #1;
        end
        check("R_in_third_load", 32'(p2s_start), 1);
        rst = 1'b1;
        #1;
        check("R_busy", 32'(busy), 0);
        check("R_start", 32'(p2s_start), 0);
        check("R_frame_done", 32'(frame_done), 0);
        check("R_data", 32'(p2s_data), 32'hFF);
        check("R_err", 32'(err), 0);
        exp_q.delete();
        fd_pending = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_frame($urandom, 8'($urandom), 8'($urandom), ND, 1'b1, t0);
        wait_fd(60, seen);
        check("R_fd_after_reset", 32'(seen), 1);
        @(negedge clk);

        // Random frames with random per-byte serializer latency
        ser_mode = 1; lat_rand = 1'b1;
        for (int f = 0; f < 20; f++) begin
            send_frame($urandom, 8'($urandom), 8'($urandom), ND, 1'b1, t0);
            wait_fd(ND * 16 + 20, seen);
            check("rand_fd_seen", 32'(seen), 1);
            @(negedge clk);
        end

        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_frame_feeder.md
# seg_frame_feeder

Upstream feeder for the display serializer (P2S stage). It accepts one display frame of NUM_DIGITS hex digits with per-digit decimal-point and blank flags on a req/busy handshake. It encodes each digit to an active-low 7-segment byte and hands the bytes one at a time to the serializer. Each byte is issued with a one-cycle start pulse, and the feeder waits for the serializer's done indication before sending the next byte.

## Interface
- NUM_DIGITS, 8, digits per frame (1..16)
- BIT_WIDTH, 8, serializer byte width; fixed at 8 for the segment encoding
- TIMEOUT, 64, max WAIT cycles per byte before abort (≥4)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  1  frame request; sampled only in IDLE
- hex_in  in  4*NUM_DIGITS  digit i = hex_in[4i+3:4i]
- dp_in  in  NUM_DIGITS  1 = decimal point on for digit i
- blank_in  in  NUM_DIGITS  1 = digit i fully off (overrides hex and dp)
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse when the last byte has completed
- err  out  1  sticky timeout flag
- p2s_start  out  1  one-cycle start pulse to the serializer
- p2s_data  out  BIT_WIDTH  byte to serialize; held stable from LOAD until the next LOAD
- p2s_done  in  1  serializer idle/complete level

## Operation
- States: IDLE, LOAD, WAIT, DONE.
- IDLE:
  - busy=0.
  - If req=1, capture hex_in, dp_in and blank_in into frame registers.
  - Set digit index idx=NUM_DIGITS-1 and go to LOAD.
- LOAD (one cycle):
  - p2s_start=1, p2s_data=enc(idx), busy=1.
  - Clear wait counter; go to WAIT.
- WAIT:
  - wait counter increments each cycle, starting at 1.
  - p2s_done is ignored while counter < 2.
  - First qualified p2s_done=1: if idx≠0, decrement idx and go to LOAD; otherwise go to DONE.
  - Counter reaching TIMEOUT without a qualified done: set err=1, go to IDLE, no frame_done.
- DONE: frame_done=1 for one cycle, busy=1; then IDLE.
- Digit order: most-significant digit (index NUM_DIGITS-1) first, digit 0 last.
- enc(): bits[6:0] = ~{g,f,e,d,c,b,a}, bit7 = ~dp.
  - Blank gives 8'hFF.
  - Examples: 0→C0, 8→80, F→8E, 8 with dp→00.
- req while busy is ignored (not queued). Input changes after capture have no effect on the current frame.
- err clears in the LOAD cycle of the next accepted frame.

## Timing
- Reset values: busy=0, frame_done=0, err=0, p2s_start=0, p2s_data=8'hFF, state IDLE, idx=0.
- req high in IDLE at edge T0 gives:
  - LOAD at T1 (busy=1, p2s_start=1);
  - first WAIT at T2;
  - earliest qualified done at T3;
  - next LOAD at T4.
- Minimum 3 cycles per digit. If p2s_done is held high, NUM_DIGITS=8 gives:
  - LOADs at T1, T4, …, T22;
  - DONE at T25;
  - busy=0 from T26.
- req sampled at T26 starts a new frame (LOAD at T27).
- p2s_start is never asserted in two consecutive cycles, and never outside LOAD.
- p2s_done is synchronous to clk; the serializer guarantees it is valid by WAIT counter 2.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously), and the frame is discarded.
- p2s_done=1 at counter exactly TIMEOUT-1 counts as success; timeout fires when the counter reaches TIMEOUT.

## Structure
- Shared display package/header `disp_pkg`:
  - state encodings (2-bit localparams);
  - SEG_BLANK=8'hFF;
  - the 16-entry hex→segment table.
- Sub-module `hex2seg`: combinational, inputs hex[3:0], dp, blank; output 8-bit active-low segment byte. Instantiated once and indexed by idx.
- Top module holds:
  - FSM;
  - frame registers;
  - idx counter (width clog2(NUM_DIGITS));
  - wait counter (width clog2(TIMEOUT+1)).

## Test plan
- Reset mid-frame at the third LOAD → busy, p2s_start and frame_done drop to 0 in the same cycle, p2s_data=FF, err=0. A new req then starts from digit 7.
- hex_in=32'h0123_4567, dp_in=0, blank_in=0, p2s_done tied 1 → p2s_data sequence C0,F9,A4,B0,99,92,82,F8. frame_done at T25, busy low at T26.
- blank_in=8'h80, dp_in=8'h01, hex_in=32'h8888_8888 → first byte FF, last byte 00, others 80.
- Serializer model raising p2s_done 9 cycles after each start → next start exactly 1 cycle after done. req pulsed mid-frame is ignored, and frame_done fires once.
- p2s_done stuck 0 with TIMEOUT=64 → err=1 after 64 WAIT cycles, busy=0, no frame_done. The next req clears err at its LOAD.
- p2s_done=1 only during WAIT counter 1 → not qualified, so the feeder stays in WAIT until p2s_done is next seen at counter ≥2.
